pc_sequencer: RTL

- Registered, parametrised program-counter sequencer for the fetch stage; supersedes the purely combinational next-PC calculation.
- Holds the fetch PC and advances it sequentially.
- Resolves PC-relative branches (B/BL), register-indirect branches (BX) and exception redirects in a fixed priority.
- Produces the link address, and inserts a programmable number of fetch bubbles after every redirect, driven by a small FSM.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with branch/exception redirect,
// link-address capture and post-redirect fetch bubbles.
module pc_sequencer #(
    parameter int                    PC_WIDTH      = 32,
    parameter int                    OFFSET_WIDTH  = 24,
    parameter int                    OFFSET_SHIFT  = 2,
    parameter int                    PC_INCR       = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR  = '0,
    parameter int                    BUBBLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch,
    input  logic                link,
    input  logic                cond_execute,
    input  logic [31:0]         inst,
    input  logic                breg_valid,
    input  logic [PC_WIDTH-1:0] breg_target,
    input  logic                exc_req,
    input  logic [PC_WIDTH-1:0] exc_vector,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                fetch_valid,
    output logic                flush,
    output logic                link_valid,
    output logic [PC_WIDTH-1:0] link_addr
);

    typedef enum logic {
        RUN,
        BUBBLE
    } state_t;

    localparam logic [PC_WIDTH-1:0] INCR = PC_WIDTH'(PC_INCR);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(INCR - 1'b1);
    localparam logic [3:0] RELOAD = 4'(BUBBLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                flush_q, flush_d;
    logic                lv_q, lv_d;
    logic [PC_WIDTH-1:0] la_q, la_d;

    logic signed [OFFSET_WIDTH-1:0] off_s;
    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] seq;
    logic [PC_WIDTH-1:0] rel;
    logic [PC_WIDTH-1:0] breg_al;
    logic [PC_WIDTH-1:0] exc_al;
    logic                unused_inst;

    // Upper instruction bits carry no information for sequencing.
    assign unused_inst = ^inst;

    // Candidate next-PC values, all modulo 2^PC_WIDTH.
    assign off_s   = inst[OFFSET_WIDTH-1:0];
    assign off_ext = PC_WIDTH'(off_s);
    assign seq     = pc_q + INCR;
    assign rel     = seq + (off_ext << OFFSET_SHIFT);
    assign breg_al = breg_target & ALIGN_MASK;
    assign exc_al  = exc_vector & ALIGN_MASK;

    // Next-state, next-PC and pulse generation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        flush_d = 1'b0;
        lv_d    = 1'b0;
        la_d    = la_q;
        unique case (state_q)
            RUN: begin
                if (exc_req) begin
                    pc_d    = exc_al;
                    state_d = BUBBLE;
                    cnt_d   = RELOAD;
                    flush_d = 1'b1;
                end else if (breg_valid && cond_execute) begin
                    pc_d    = breg_al;
                    state_d = BUBBLE;
                    cnt_d   = RELOAD;
                    flush_d = 1'b1;
                    if (link) begin
                        lv_d = 1'b1;
                        la_d = seq;
                    end
                end else if (branch && cond_execute) begin
                    pc_d    = rel;
                    state_d = BUBBLE;
                    cnt_d   = RELOAD;
                    flush_d = 1'b1;
                    if (link) begin
                        lv_d = 1'b1;
                        la_d = seq;
                    end
                end else if (!stall) begin
                    pc_d = seq;
                end
            end
            BUBBLE: begin
                if (exc_req) begin
                    pc_d    = exc_al;
                    cnt_d   = RELOAD;
                    flush_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= 4'd0;
            flush_q <= 1'b0;
            lv_q    <= 1'b0;
            la_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            lv_q    <= lv_d;
            la_q    <= la_d;
        end
    end

    assign pc_out      = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign flush       = flush_q;
    assign link_valid  = lv_q;
    assign link_addr   = la_q;

endmodule
